// File: rtl/hist_accumulator_pkg.sv
// Shared types and defaults for the histogram write stage.
// Imported by hist_accumulator and the readout side.
package hist_accumulator_pkg;

    localparam int DEF_PIXEL_BITS = 10;
    localparam int DEF_BIN_BITS   = 10;
    localparam int DEF_COUNT_BITS = 32;
    localparam int PCNT_BITS      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/hist_accumulator.sv
// Histogram write stage: clears the bin RAM, then does a pipelined
// read-modify-write increment per pixel with S2->S1 forwarding.
module hist_accumulator
    import hist_accumulator_pkg::*;
#(
    parameter int PIXEL_BITS = DEF_PIXEL_BITS,
    parameter int BIN_BITS   = DEF_BIN_BITS,
    parameter int COUNT_BITS = DEF_COUNT_BITS
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  FrameStart,
    input  logic                  FrameEnd,
    input  logic                  PixelValid,
    input  logic [PIXEL_BITS-1:0] PixelData,
    output logic                  PixelReady,
    output logic [BIN_BITS-1:0]   RamWrAddress,
    output logic [COUNT_BITS-1:0] RamData,
    output logic                  RamWE,
    output logic                  RamWrClockEn,
    output logic [BIN_BITS-1:0]   RamRdAddress,
    input  logic [COUNT_BITS-1:0] RamQ,
    output logic [PCNT_BITS-1:0]  PixelCount,
    output logic                  HistDone,
    output logic                  Busy
);

    state_t state;
    state_t stateNext;

    logic [BIN_BITS-1:0]   clrAddr;
    logic                  drainLast;
    logic [BIN_BITS-1:0]   b1;
    logic [BIN_BITS-1:0]   b2;
    logic                  v1;
    logic                  v2;
    logic [COUNT_BITS-1:0] c2;
    logic [COUNT_BITS-1:0] operand;
    logic [COUNT_BITS-1:0] countNext;
    logic [BIN_BITS-1:0]   pixelBin;
    logic                  accept;
    logic                  pipeActive;

    assign pixelBin   = PixelData[PIXEL_BITS-1 -: BIN_BITS];
    assign PixelReady = (state == ST_ACCUM);
    assign accept     = PixelReady && PixelValid;
    assign pipeActive = (state == ST_ACCUM) || (state == ST_DRAIN);

    // S2 holds a write the RAM has not absorbed yet; forward it on a bin hit.
    assign operand   = (v2 && (b2 == b1)) ? c2 : RamQ;
    assign countNext = (operand == '1) ? operand : operand + 1'b1;

    assign RamRdAddress = (state == ST_CLEAR) ? clrAddr : b1;
    assign RamWrAddress = (state == ST_CLEAR) ? clrAddr : b2;
    assign RamData      = (state == ST_CLEAR) ? '0 : c2;
    assign RamWE        = (state == ST_CLEAR) || v2;
    assign RamWrClockEn = 1'b1;
    assign Busy         = (state == ST_CLEAR) || (state == ST_DRAIN);
    assign HistDone     = (state == ST_DONE);

    always_comb begin
        stateNext = state;
        if (FrameStart) begin
            stateNext = ST_CLEAR;
        end else begin
            unique case (state)
                ST_IDLE:  stateNext = ST_IDLE;
                ST_CLEAR: if (clrAddr == '1) stateNext = ST_ACCUM;
                ST_ACCUM: if (FrameEnd) stateNext = ST_DRAIN;
                ST_DRAIN: if (drainLast) stateNext = ST_DONE;
                ST_DONE:  stateNext = ST_IDLE;
                default:  stateNext = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            clrAddr   <= '0;
            drainLast <= 1'b0;
        end else begin
            state <= stateNext;
            if (FrameStart)
                clrAddr <= '0;
            else if (state == ST_CLEAR)
                clrAddr <= clrAddr + 1'b1;
            drainLast <= (state == ST_DRAIN) && !drainLast;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            b1 <= '0;
            b2 <= '0;
            c2 <= '0;
        end else begin
            v1 <= accept && !FrameStart;
            v2 <= v1 && pipeActive && !FrameStart;
            if (accept)
                b1 <= pixelBin;
            if (v1) begin
                b2 <= b1;
                c2 <= countNext;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            PixelCount <= '0;
        else if (FrameStart)
            PixelCount <= '0;
        else if (accept && (PixelCount != '1))
            PixelCount <= PixelCount + 1'b1;
    end

endmodule

// File: tb/tb_hist_accumulator.sv
// Bench: hist_accumulator paired with a dual-port RAM model and a
// write scoreboard fed from a reference histogram.
module tb_hist_accumulator;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        FrameStart;
    logic        FrameEnd;
    logic        PixelValid;
    logic [9:0]  PixelData;
    logic        PixelReady;
    logic [9:0]  RamWrAddress;
    logic [31:0] RamData;
    logic        RamWE;
    logic        RamWrClockEn;
    logic [9:0]  RamRdAddress;
    logic [31:0] RamQ;
    logic [31:0] PixelCount;
    logic        HistDone;
    logic        Busy;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    int          hdCount = 0;
    bit          sbOn = 1'b0;
    wr_t         sbq[$];
    logic [31:0] model[1024];
    logic [31:0] mem[1024];
    logic        bdWe = 1'b0;
    logic [9:0]  bdAddr = '0;
    logic [31:0] bdData = '0;

    always #5 Clock = ~Clock;

    hist_accumulator dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .FrameStart   (FrameStart),
        .FrameEnd     (FrameEnd),
        .PixelValid   (PixelValid),
        .PixelData    (PixelData),
        .PixelReady   (PixelReady),
        .RamWrAddress (RamWrAddress),
        .RamData      (RamData),
        .RamWE        (RamWE),
        .RamWrClockEn (RamWrClockEn),
        .RamRdAddress (RamRdAddress),
        .RamQ         (RamQ),
        .PixelCount   (PixelCount),
        .HistDone     (HistDone),
        .Busy         (Busy)
    );

    // soft_ram_dp model: async read, sync write, plus a bench backdoor
    assign RamQ = mem[RamRdAddress];
    always @(posedge Clock) begin
        if (bdWe)
            mem[bdAddr] <= bdData;
        else if (RamWrClockEn && RamWE)
            mem[RamWrAddress] <= RamData;
    end

    always @(negedge Clock) begin
        if (HistDone === 1'b1)
            hdCount++;
        if (sbOn && RamWE === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected addr=%0d data=%h",
                         RamWrAddress, RamData);
            end else begin
                wr_t e;
                e = sbq.pop_front();
                if (RamWrAddress !== e.a || RamData !== e.d) begin
                    errors++;
                    $display("FAIL sb_write got %0d:%h want %0d:%h",
                             RamWrAddress, RamData, e.a, e.d);
                end
            end
        end
    end

    function automatic logic [31:0] satp1(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 1024; i++)
            model[i] = '0;
        sbq.delete();
    endtask

    task automatic doClear();
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
        repeat (1024) tick();
        clearModel();
    endtask

    task automatic feed(input logic [9:0] px, input bit withEnd,
                        input bit track);
        PixelValid = 1'b1;
        PixelData  = px;
        FrameEnd   = withEnd;
        if (track) begin
            model[px] = satp1(model[px]);
            sbq.push_back('{a: px, d: model[px]});
        end
        tick();
        PixelValid = 1'b0;
        FrameEnd   = 1'b0;
    endtask

    task automatic test_reset();
        Reset      = 1'b1;
        FrameStart = 1'b0;
        FrameEnd   = 1'b0;
        PixelValid = 1'b0;
        PixelData  = '0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        checks++;
        if ({PixelReady, RamWE, HistDone, Busy} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {PixelReady, RamWE, HistDone, Busy});
        end
        checks++;
        if (RamWrClockEn !== 1'b1) begin
            errors++;
            $display("FAIL reset_clken got %b want 1", RamWrClockEn);
        end
        checks++;
        if (PixelCount !== 32'd0 || RamData !== 32'd0 ||
            RamWrAddress !== 10'd0 || RamRdAddress !== 10'd0) begin
            errors++;
            $display("FAIL reset_values pc=%0d d=%h wa=%0d ra=%0d want 0",
                     PixelCount, RamData, RamWrAddress, RamRdAddress);
        end
        // FrameEnd while idle must do nothing
        FrameEnd = 1'b1;
        tick();
        FrameEnd = 1'b0;
        repeat (4) tick();
        checks++;
        if (Busy !== 1'b0 || PixelReady !== 1'b0 || hdCount != 0) begin
            errors++;
            $display("FAIL idle_frameend busy=%b rdy=%b hd=%0d want 0 0 0",
                     Busy, PixelReady, hdCount);
        end
    endtask

    task automatic test_clear();
        int bad;
        int busyCycles;
        bad = 0;
        busyCycles = 0;
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
        for (int i = 0; i < 1100 && Busy === 1'b1; i++) begin
            busyCycles++;
            if (RamWE !== 1'b1 || RamData !== 32'd0 ||
                RamWrAddress !== 10'(i))
                bad++;
            tick();
        end
        checks++;
        if (busyCycles != 1024) begin
            errors++;
            $display("FAIL clear_busy got %0d cycles want 1024", busyCycles);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_writes got %0d bad cycles want 0", bad);
        end
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== 32'd0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_ram got %0d nonzero want 0", bad);
        end
        checks++;
        if (PixelReady !== 1'b1 || PixelCount !== 32'd0) begin
            errors++;
            $display("FAIL clear_accum rdy=%b pc=%0d want 1 0",
                     PixelReady, PixelCount);
        end
        clearModel();
    endtask

    task automatic test_all_bins();
        int at;
        int bad;
        at = 0;
        bad = 0;
        sbOn = 1'b1;
        for (int i = 0; i < 1024; i++)
            feed(10'(i), 1'b0, 1'b1);
        FrameEnd = 1'b1;
        tick();
        FrameEnd = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            if (HistDone === 1'b1 && at == 0) at = j;
            tick();
        end
        sbOn = 1'b0;
        checks++;
        if (at != 3) begin
            errors++;
            $display("FAIL done_latency got %0d want 3", at);
        end
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== 32'd1) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL all_bins got %0d bins != 1 want 0", bad);
        end
        checks++;
        if (PixelCount !== 32'd1024) begin
            errors++;
            $display("FAIL all_pcount got %0d want 1024", PixelCount);
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL all_pending got %0d want 0", sbq.size());
        end
    endtask

    task automatic test_forwarding();
        int bad;
        bad = 0;
        doClear();
        sbOn = 1'b1;
        for (int i = 0; i < 100; i++)
            feed(10'd5, 1'b0, 1'b1);
        FrameEnd = 1'b1;
        tick();
        FrameEnd = 1'b0;
        repeat (4) tick();
        sbOn = 1'b0;
        checks++;
        if (mem[5] !== 32'd100) begin
            errors++;
            $display("FAIL fwd_bin5 got %0d want 100", mem[5]);
        end
        for (int i = 0; i < 1024; i++)
            if (i != 5 && mem[i] !== 32'd0) bad++;
        checks++;
        if (bad != 0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL fwd_others got %0d nonzero, %0d pending want 0 0",
                     bad, sbq.size());
        end
        checks++;
        if (PixelCount !== 32'd100) begin
            errors++;
            $display("FAIL fwd_pcount got %0d want 100", PixelCount);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] seq[7];
        int hd0;
        seq = '{10'd7, 10'd9, 10'd7, 10'd9, 10'd7, 10'd7, 10'd7};
        doClear();
        hd0 = hdCount;
        sbOn = 1'b1;
        // last pixel rides together with FrameEnd
        for (int i = 0; i < 7; i++)
            feed(seq[i], i == 6, 1'b1);
        repeat (5) tick();
        sbOn = 1'b0;
        checks++;
        if (mem[7] !== 32'd5 || mem[9] !== 32'd2) begin
            errors++;
            $display("FAIL b2b_bins got %0d,%0d want 5,2", mem[7], mem[9]);
        end
        checks++;
        if (PixelCount !== 32'd7 || hdCount != hd0 + 1) begin
            errors++;
            $display("FAIL b2b_done pc=%0d hd=%0d want 7 %0d",
                     PixelCount, hdCount - hd0, 1);
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL b2b_pending got %0d want 0", sbq.size());
        end
    endtask

    task automatic test_saturate();
        doClear();
        bdWe   = 1'b1;
        bdAddr = 10'd3;
        bdData = 32'hFFFF_FFFE;
        tick();
        bdWe = 1'b0;
        model[3] = 32'hFFFF_FFFE;
        sbOn = 1'b1;
        for (int i = 0; i < 3; i++)
            feed(10'd3, 1'b0, 1'b1);
        FrameEnd = 1'b1;
        tick();
        FrameEnd = 1'b0;
        repeat (4) tick();
        sbOn = 1'b0;
        checks++;
        if (mem[3] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_bin3 got %h want ffffffff", mem[3]);
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sat_pending got %0d want 0", sbq.size());
        end
    endtask

    task automatic test_restart();
        int bad;
        int busyCycles;
        int hd0;
        doClear();
        feed(10'd11, 1'b0, 1'b0);
        feed(10'd12, 1'b0, 1'b0);
        // v1 and v2 both hold pixels now
        PixelValid = 1'b1;
        PixelData  = 10'd13;
        FrameStart = 1'b1;
        tick();
        PixelValid = 1'b0;
        FrameStart = 1'b0;
        busyCycles = 0;
        for (int i = 0; i < 1100 && Busy === 1'b1; i++) begin
            busyCycles++;
            tick();
        end
        repeat (3) tick();
        checks++;
        if (busyCycles != 1024) begin
            errors++;
            $display("FAIL restart_busy got %0d want 1024", busyCycles);
        end
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== 32'd0) bad++;
        checks++;
        if (bad != 0 || PixelCount !== 32'd0) begin
            errors++;
            $display("FAIL restart_ram got %0d nonzero pc=%0d want 0 0",
                     bad, PixelCount);
        end
        hd0 = hdCount;
        FrameStart = 1'b1;
        FrameEnd   = 1'b1;
        tick();
        FrameStart = 1'b0;
        FrameEnd   = 1'b0;
        checks++;
        if (Busy !== 1'b1 || PixelReady !== 1'b0) begin
            errors++;
            $display("FAIL start_end_clear busy=%b rdy=%b want 1 0",
                     Busy, PixelReady);
        end
        repeat (1030) tick();
        checks++;
        if (hdCount != hd0 || PixelReady !== 1'b1) begin
            errors++;
            $display("FAIL start_end_done hd=%0d rdy=%b want 0 1",
                     hdCount - hd0, PixelReady);
        end
        // reset mid-frame: pipeline dropped, no completion pulse
        feed(10'd20, 1'b0, 1'b0);
        PixelValid = 1'b1;
        PixelData  = 10'd21;
        Reset      = 1'b1;
        tick();
        PixelValid = 1'b0;
        checks++;
        if ({PixelReady, RamWE, Busy, HistDone} !== 4'b0 ||
            PixelCount !== 32'd0) begin
            errors++;
            $display("FAIL midreset got %b pc=%0d want 0000 0",
                     {PixelReady, RamWE, Busy, HistDone}, PixelCount);
        end
        Reset = 1'b0;
        repeat (5) tick();
        checks++;
        if (hdCount != hd0 || mem[20] !== 32'd0 || mem[21] !== 32'd0) begin
            errors++;
            $display("FAIL midreset_quiet hd=%0d b20=%0d b21=%0d want 0 0 0",
                     hdCount - hd0, mem[20], mem[21]);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_all_bins();
        test_forwarding();
        test_back_to_back();
        test_saturate();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
